// File: rtl/rectangle_pkg.sv
// Shared constants, types and helpers for the RECTANGLE-80 key schedule.
package rectangle_pkg;

    localparam int unsigned KEY_W     = 80;
    localparam int unsigned BLK_W     = 64;
    localparam int unsigned ROW_W     = 16;
    localparam int unsigned NUM_ROWS  = 5;
    localparam int unsigned SBOX_COLS = 4;
    localparam int unsigned NIB_W     = 4;
    localparam int unsigned RC_W      = 5;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned NUM_RK    = 26;

    localparam logic [RC_W-1:0] RC_INIT = 5'h01;

    // S-box entry i lives at bits [4i+3:4i]: 6,5,C,A,1,E,7,9,B,0,3,D,8,F,4,2
    localparam logic [63:0] SBOX_TABLE = 64'h24F8_D30B_97E1_AC56;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    function automatic logic [RC_W-1:0] lfsr_next(input logic [RC_W-1:0] rc);
        return {rc[3:0], rc[4] ^ rc[2]};
    endfunction

    function automatic logic [ROW_W-1:0] rotl8(input logic [ROW_W-1:0] x);
        return {x[7:0], x[15:8]};
    endfunction

    function automatic logic [ROW_W-1:0] rotl12(input logic [ROW_W-1:0] x);
        return {x[3:0], x[15:4]};
    endfunction

endpackage

// File: rtl/rectangle_sbox.sv
// 4-bit RECTANGLE S-box, purely combinational; shared with the datapath SubColumn layer.
module rectangle_sbox
    import rectangle_pkg::*;
(
    input  logic [NIB_W-1:0] nib,
    output logic [NIB_W-1:0] sub_c
);

    always_comb begin
        sub_c = SBOX_TABLE[{nib, 2'b00} +: NIB_W];
    end

endmodule

// File: rtl/rectangle_key_schedule.sv
// RECTANGLE-80 key schedule: emits 26 round keys over a valid/ready handshake,
// advancing the 80-bit key state once per accepted key.
module rectangle_key_schedule
    import rectangle_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [KEY_W-1:0]  key_in,
    output logic              busy,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic [BLK_W-1:0]  rk_out,
    output logic [IDX_W-1:0]  rk_idx,
    output logic              done
);

    state_e             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d, key_upd;
    logic [RC_W-1:0]    rc_q, rc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               done_q, done_d;

    logic [ROW_W-1:0]   row  [NUM_ROWS];
    logic [ROW_W-1:0]   srow [NUM_ROWS];
    logic [ROW_W-1:0]   mrow [NUM_ROWS];
    logic [NIB_W-1:0]   col_in  [SBOX_COLS];
    logic [NIB_W-1:0]   col_out [SBOX_COLS];

    // Split key state into rows, row 0 in the least significant bits
    always_comb begin
        for (int r = 0; r < int'(NUM_ROWS); r++) begin
            row[r] = key_q[r*ROW_W +: ROW_W];
        end
    end

    // S-box layer only touches the four lowest columns
    for (genvar j = 0; j < SBOX_COLS; j++) begin : g_sbox
        assign col_in[j] = {row[3][j], row[2][j], row[1][j], row[0][j]};

        rectangle_sbox u_sbox (
            .nib   (col_in[j]),
            .sub_c (col_out[j])
        );
    end

    always_comb begin
        for (int r = 0; r < int'(NUM_ROWS); r++) begin
            srow[r] = row[r];
        end
        for (int j = 0; j < int'(SBOX_COLS); j++) begin
            srow[0][j] = col_out[j][0];
            srow[1][j] = col_out[j][1];
            srow[2][j] = col_out[j][2];
            srow[3][j] = col_out[j][3];
        end
    end

    // Row mix (generalised Feistel) plus round-constant injection
    always_comb begin
        mrow[0] = rotl8(srow[0]) ^ srow[1];
        mrow[1] = srow[2];
        mrow[2] = srow[3];
        mrow[3] = rotl12(srow[3]) ^ srow[4];
        mrow[4] = srow[0];
        mrow[0][RC_W-1:0] = mrow[0][RC_W-1:0] ^ rc_q;
        key_upd = {mrow[4], mrow[3], mrow[2], mrow[1], mrow[0]};
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rc_d    = rc_q;
        idx_d   = idx_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    rc_d    = RC_INIT;
                    idx_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (idx_q == IDX_W'(NUM_RK - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d = key_upd;
                        rc_d  = lfsr_next(rc_q);
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            rc_q    <= RC_INIT;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            rc_q    <= rc_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q == EMIT);
    assign rk_valid = (state_q == EMIT);
    assign rk_out   = key_q[BLK_W-1:0];
    assign rk_idx   = idx_q;
    assign done     = done_q;

endmodule

// File: tb/tb_rectangle_key_schedule.sv
// Scoreboard bench for rectangle_key_schedule: a bit-level reference model
// queues every expected round key when a schedule is started.
module tb_rectangle_key_schedule;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [79:0] key_in = '0;
    logic        busy;
    logic        rk_valid;
    logic        rk_ready = 1'b0;
    logic [63:0] rk_out;
    logic [4:0]  rk_idx;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  idx;
        logic [63:0] rk;
    } exp_t;

    exp_t sb[$];

    logic [3:0] sbox_tab [16] = '{4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
                                  4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2};

    rectangle_key_schedule dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [79:0] model_next(input logic [79:0] k, input logic [4:0] rc);
        logic [15:0] r [5];
        logic [15:0] n [5];
        logic [3:0]  nib;
        logic [3:0]  s;
        for (int i = 0; i < 5; i++) r[i] = k[16*i +: 16];
        for (int j = 0; j < 4; j++) begin
            nib = {r[3][j], r[2][j], r[1][j], r[0][j]};
            s = sbox_tab[nib];
            r[0][j] = s[0];
            r[1][j] = s[1];
            r[2][j] = s[2];
            r[3][j] = s[3];
        end
        n[0] = ((r[0] << 8) | (r[0] >> 8)) ^ r[1];
        n[1] = r[2];
        n[2] = r[3];
        n[3] = ((r[3] << 12) | (r[3] >> 4)) ^ r[4];
        n[4] = r[0];
        n[0][4:0] = n[0][4:0] ^ rc;
        return {n[4], n[3], n[2], n[1], n[0]};
    endfunction

    task automatic push_schedule(input logic [79:0] k);
        logic [79:0] kk;
        logic [4:0]  rc;
        exp_t        e;
        kk = k;
        rc = 5'h01;
        for (int i = 0; i < 26; i++) begin
            e.idx = 5'(i);
            e.rk  = kk[63:0];
            sb.push_back(e);
            kk = model_next(kk, rc);
            rc = {rc[3:0], rc[4] ^ rc[2]};
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        rk_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, rk_valid, done, rk_idx, rk_out} !== 72'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got busy=%b valid=%b done=%b idx=%0d rk=%h required all 0",
                     busy, rk_valid, done, rk_idx, rk_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || rk_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset got busy=%b valid=%b done=%b required 0 0 0", busy, rk_valid, done);
        end
    endtask

    task automatic test_zero_key_backpressure();
        exp_t e;
        bit   seen;
        @(posedge clk); #1;
        key_in = '0;
        start = 1'b1;
        rk_ready = 1'b1;
        push_schedule(80'h0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rk_valid !== 1'b1 || busy !== 1'b1 || rk_idx !== 5'd0 || rk_out !== 64'h0) begin
            n_fail++;
            $display("FAIL zero_key_first got valid=%b busy=%b idx=%0d rk=%h required 1 1 0 0", rk_valid, busy, rk_idx, rk_out);
        end
        if (rk_valid && rk_ready) begin
            n_checks++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL sb_empty got idx=%0d required no key", rk_idx); end
            else begin
                e = sb.pop_front();
                if (rk_idx !== e.idx || rk_out !== e.rk) begin
                    n_fail++;
                    $display("FAIL sb_key got idx=%0d rk=%h required idx=%0d rk=%h", rk_idx, rk_out, e.idx, e.rk);
                end
            end
        end
        @(posedge clk); #1;
        rk_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (rk_valid !== 1'b1 || rk_idx !== 5'd1 || rk_out !== 64'h0000_0000_000F_000E) begin
                n_fail++;
                $display("FAIL stall_hold got valid=%b idx=%0d rk=%h required 1 1 000000000000f000e", rk_valid, rk_idx, rk_out);
            end
            @(posedge clk); #1;
        end
        rk_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_checks++;
                if (rk_idx !== 5'd2) begin
                    n_fail++;
                    $display("FAIL release_idx got %0d required 2", rk_idx);
                end
            end
            if (done) seen = 1'b1;
            if (rk_valid && rk_ready) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL sb_empty got idx=%0d required no key", rk_idx); end
                else begin
                    e = sb.pop_front();
                    if (rk_idx !== e.idx || rk_out !== e.rk) begin
                        n_fail++;
                        $display("FAIL sb_key got idx=%0d rk=%h required idx=%0d rk=%h", rk_idx, rk_out, e.idx, e.rk);
                    end
                end
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (!seen || sb.size() != 0) begin
            n_fail++;
            $display("FAIL zero_key_drain got done_seen=%b left=%0d required 1 0", seen, sb.size());
        end
    endtask

    task automatic test_full_run(input logic [79:0] key);
        exp_t e;
        @(posedge clk); #1;
        key_in = key;
        start = 1'b1;
        rk_ready = 1'b1;
        push_schedule(key);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            n_checks++;
            if (rk_valid !== 1'b1 || busy !== 1'b1 || rk_idx !== 5'(i) || done !== 1'b0) begin
                n_fail++;
                $display("FAIL full_seq got valid=%b busy=%b idx=%0d done=%b required 1 1 %0d 0", rk_valid, busy, rk_idx, done, i);
            end
            if (rk_valid && rk_ready) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL sb_empty got idx=%0d required no key", rk_idx); end
                else begin
                    e = sb.pop_front();
                    if (rk_idx !== e.idx || rk_out !== e.rk) begin
                        n_fail++;
                        $display("FAIL sb_key got idx=%0d rk=%h required idx=%0d rk=%h", rk_idx, rk_out, e.idx, e.rk);
                    end
                end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || rk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse got done=%b busy=%b valid=%b required 1 0 0", done, busy, rk_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL done_once got done=%b busy=%b left=%0d required 0 0 0", done, busy, sb.size());
        end
    endtask

    task automatic test_start_while_busy(input logic [79:0] ka, input logic [79:0] kb);
        exp_t e;
        @(posedge clk); #1;
        key_in = ka;
        start = 1'b1;
        rk_ready = 1'b1;
        push_schedule(ka);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            if (i == 7) begin
                n_checks++;
                if (rk_idx !== 5'd7 || start !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_start_setup got idx=%0d start=%b required 7 1", rk_idx, start);
                end
            end
            if (rk_valid && rk_ready) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL sb_empty got idx=%0d required no key", rk_idx); end
                else begin
                    e = sb.pop_front();
                    if (rk_idx !== e.idx || rk_out !== e.rk) begin
                        n_fail++;
                        $display("FAIL sb_key got idx=%0d rk=%h required idx=%0d rk=%h", rk_idx, rk_out, e.idx, e.rk);
                    end
                end
            end
            @(posedge clk); #1;
            start  = (i == 6);
            key_in = (i == 6) ? kb : ka;
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL busy_start_done got done=%b left=%0d required 1 0", done, sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back(input logic [79:0] ka, input logic [79:0] kb);
        exp_t e;
        bit   seen;
        @(posedge clk); #1;
        key_in = ka;
        start = 1'b1;
        rk_ready = 1'b1;
        push_schedule(ka);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            if (rk_valid && rk_ready) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL sb_empty got idx=%0d required no key", rk_idx); end
                else begin
                    e = sb.pop_front();
                    if (rk_idx !== e.idx || rk_out !== e.rk) begin
                        n_fail++;
                        $display("FAIL sb_key got idx=%0d rk=%h required idx=%0d rk=%h", rk_idx, rk_out, e.idx, e.rk);
                    end
                end
            end
            @(posedge clk); #1;
        end
        key_in = kb;
        start = 1'b1;
        push_schedule(kb);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done got done=%b required 1", done);
        end
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_checks++;
                if (rk_valid !== 1'b1 || rk_idx !== 5'd0 || rk_out !== kb[63:0] || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_first got valid=%b idx=%0d rk=%h done=%b required 1 0 %h 0",
                             rk_valid, rk_idx, rk_out, done, kb[63:0]);
                end
            end
            if (done) seen = 1'b1;
            if (rk_valid && rk_ready) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL sb_empty got idx=%0d required no key", rk_idx); end
                else begin
                    e = sb.pop_front();
                    if (rk_idx !== e.idx || rk_out !== e.rk) begin
                        n_fail++;
                        $display("FAIL sb_key got idx=%0d rk=%h required idx=%0d rk=%h", rk_idx, rk_out, e.idx, e.rk);
                    end
                end
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (!seen || sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain got done_seen=%b left=%0d required 1 0", seen, sb.size());
        end
    endtask

    task automatic test_reset_mid_run(input logic [79:0] key);
        exp_t e;
        @(posedge clk); #1;
        key_in = key;
        start = 1'b1;
        rk_ready = 1'b1;
        push_schedule(key);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rk_valid && rk_ready) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL sb_empty got idx=%0d required no key", rk_idx); end
                else begin
                    e = sb.pop_front();
                    if (rk_idx !== e.idx || rk_out !== e.rk) begin
                        n_fail++;
                        $display("FAIL sb_key got idx=%0d rk=%h required idx=%0d rk=%h", rk_idx, rk_out, e.idx, e.rk);
                    end
                end
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, rk_valid, done, rk_idx, rk_out} !== 72'h0) begin
            n_fail++;
            $display("FAIL mid_reset got busy=%b valid=%b done=%b idx=%0d rk=%h required all 0",
                     busy, rk_valid, done, rk_idx, rk_out);
        end
        sb.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || rk_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset_hold got done=%b valid=%b required 0 0", done, rk_valid);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_release got busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    initial begin
        logic [79:0] ka;
        logic [79:0] kb;
        ka = 80'({$urandom(), $urandom(), $urandom()});
        kb = 80'({$urandom(), $urandom(), $urandom()});
        test_reset();
        test_zero_key_backpressure();
        test_full_run(80'h0123_4567_89AB_CDEF_FEDC);
        test_full_run(ka);
        test_start_while_busy(kb, ka);
        test_back_to_back(80'hFFFF_FFFF_FFFF_FFFF_FFFF, 80'h8000_0000_0000_0000_0001);
        test_reset_mid_run(ka);
        test_full_run(kb);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
